// File: rtl/snake_pkg.sv
// Shared sizes, scan FSM encoding and the line-slot record for the snake renderer.
package snake_pkg;
  localparam int COORD_W    = 10;
  localparam int MAX_SEG    = 30;
  localparam int SEG_SIZE   = 5;
  localparam int LINE_SLOTS = 8;
  localparam int LEN_W      = 7;

  typedef enum logic {IDLE, SCAN} state_t;

  typedef struct packed {
    logic               valid;
    logic               head;
    logic [COORD_W-1:0] x;
  } slot_t;

  // One extra bit on the upper bound so a segment near 1023 never wraps to 0.
  function automatic logic in_span(input logic [COORD_W-1:0] lo, input logic [COORD_W-1:0] v);
    logic [COORD_W:0] hi;
    hi = {1'b0, lo} + (COORD_W+1)'(SEG_SIZE - 1);
    return ({1'b0, v} >= {1'b0, lo}) && ({1'b0, v} <= hi);
  endfunction
endpackage

// File: rtl/snake_line_buffer.sv
// Per-scanline hit list: LINE_SLOTS recorded segments plus the parallel x-range compare.
module snake_line_buffer
  import snake_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               append,
  input  logic [COORD_W-1:0] app_x,
  input  logic               app_head,
  output logic               full,
  input  logic [COORD_W-1:0] pix_x,
  output logic               hit_any,
  output logic               hit_head
);
  localparam int CW = $clog2(LINE_SLOTS + 1);
  localparam int IW = $clog2(LINE_SLOTS);

  slot_t [LINE_SLOTS-1:0] slots;
  logic  [CW-1:0]         cnt;
  logic  [LINE_SLOTS-1:0] hit_v, head_v;

  assign full = (cnt == CW'(LINE_SLOTS));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slots <= '0;
      cnt   <= '0;
    end else if (clear) begin
      slots <= '0;
      cnt   <= '0;
    end else if (append && !full) begin
      slots[cnt[IW-1:0]] <= '{valid: 1'b1, head: app_head, x: app_x};
      cnt                <= cnt + CW'(1);
    end
  end

  for (genvar g = 0; g < LINE_SLOTS; g++) begin : g_cmp
    assign hit_v[g]  = slots[g].valid && in_span(slots[g].x, pix_x);
    assign head_v[g] = hit_v[g] && slots[g].head;
  end

  assign hit_any  = |hit_v;
  assign hit_head = |head_v;
endmodule

// File: rtl/snake_renderer.sv
// Snake body pixel renderer: per-frame snapshot, per-hblank line scan, 1-cycle pixel match.
module snake_renderer
  import snake_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       frame_start,
  input  logic                       line_start,
  input  logic [COORD_W-1:0]         next_y,
  input  logic                       pix_valid,
  input  logic [COORD_W-1:0]         pix_x,
  input  logic [MAX_SEG*COORD_W-1:0] body_x,
  input  logic [MAX_SEG*COORD_W-1:0] body_y,
  input  logic [LEN_W-1:0]           body_len,
  output logic                       pixel_on,
  output logic                       head_on,
  output logic                       busy,
  output logic                       overflow
);
  localparam int IDX_W = $clog2(MAX_SEG);

  logic [MAX_SEG-1:0][COORD_W-1:0] snap_x, snap_y;
  logic [LEN_W-1:0]   len, idx, len_clamp;
  logic [COORD_W-1:0] line_y;
  logic               pending;
  state_t             state;

  logic restart, seg_hit, last, full, hit_any, hit_head;

  assign len_clamp = (body_len > LEN_W'(MAX_SEG)) ? LEN_W'(MAX_SEG) : body_len;
  assign restart   = frame_start || line_start || pending;
  assign seg_hit   = (state == SCAN) && (len != '0) && in_span(snap_y[idx[IDX_W-1:0]], line_y);
  assign last      = (len == '0) || (idx == len - LEN_W'(1));

  snake_line_buffer u_line (
    .clk      (clk),
    .rst      (rst),
    .clear    (restart),
    .append   (seg_hit && !restart),
    .app_x    (snap_x[idx[IDX_W-1:0]]),
    .app_head (idx == '0),
    .full     (full),
    .pix_x    (pix_x),
    .hit_any  (hit_any),
    .hit_head (hit_head)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= '0;
      len      <= '0;
      line_y   <= '0;
      pending  <= 1'b0;
      busy     <= 1'b0;
      overflow <= 1'b0;
      snap_x   <= '0;
      snap_y   <= '0;
      pixel_on <= 1'b0;
      head_on  <= 1'b0;
    end else begin
      // A half-built list is never shown: busy blanks the pixel path.
      pixel_on <= pix_valid && !busy && hit_any;
      head_on  <= pix_valid && !busy && hit_head;
      if (frame_start) begin
        snap_x   <= body_x;
        snap_y   <= body_y;
        len      <= len_clamp;
        overflow <= 1'b0;
        state    <= IDLE;
        busy     <= 1'b0;
        idx      <= '0;
        pending  <= line_start;
        if (line_start) line_y <= next_y;
      end else if (line_start || pending) begin
        state   <= SCAN;
        busy    <= 1'b1;
        idx     <= '0;
        pending <= 1'b0;
        if (line_start) line_y <= next_y;
      end else if (state == SCAN) begin
        if (seg_hit && full) overflow <= 1'b1;
        if (last) begin
          state <= IDLE;
          busy  <= 1'b0;
        end else begin
          idx <= idx + LEN_W'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_snake_renderer.sv
// Directed bench for snake_renderer with a list-level reference model checked every cycle.
module tb_snake_renderer;
  import snake_pkg::*;

  logic clk = 1'b0, rst = 1'b1;
  logic frame_start = 1'b0, line_start = 1'b0, pix_valid = 1'b0;
  logic [COORD_W-1:0] next_y = '0, pix_x = '0;
  logic [MAX_SEG*COORD_W-1:0] body_x = '0, body_y = '0;
  logic [LEN_W-1:0] body_len = '0;
  logic pixel_on, head_on, busy, overflow;

  int total = 0, bad = 0;

  snake_renderer dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .line_start(line_start),
    .next_y(next_y), .pix_valid(pix_valid), .pix_x(pix_x),
    .body_x(body_x), .body_y(body_y), .body_len(body_len),
    .pixel_on(pixel_on), .head_on(head_on), .busy(busy), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d @%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: snapshot arrays and the scanline list as a queue.
  typedef struct { int x; bit head; } seg_t;
  int   m_sx[MAX_SEG], m_sy[MAX_SEG];
  int   m_len = 0, m_busy_left = 0, m_pend_y = 0;
  bit   m_pending = 0, m_ovf = 0, m_new_ovf = 0, m_pix_on = 0, m_head_on = 0;
  seg_t m_list[$], m_new[$];

  task automatic m_start(input int y);
    int hits = 0;
    m_list.delete();
    m_new.delete();
    for (int i = 0; i < m_len; i++)
      if (y >= m_sy[i] && y <= m_sy[i] + SEG_SIZE - 1) begin
        hits++;
        if (m_new.size() < LINE_SLOTS) m_new.push_back('{x: m_sx[i], head: (i == 0)});
      end
    m_new_ovf   = hits > LINE_SLOTS;
    m_busy_left = (m_len > 1) ? m_len : 1;
    m_pending   = 0;
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_len = 0; m_busy_left = 0; m_pending = 0; m_ovf = 0;
      m_pix_on = 0; m_head_on = 0; m_list.delete();
    end else begin
      m_pix_on = 0; m_head_on = 0;
      if (pix_valid && m_busy_left == 0)
        foreach (m_list[k])
          if (int'(pix_x) >= m_list[k].x && int'(pix_x) <= m_list[k].x + SEG_SIZE - 1) begin
            m_pix_on = 1;
            if (m_list[k].head) m_head_on = 1;
          end
      if (frame_start) begin
        for (int i = 0; i < MAX_SEG; i++) begin
          m_sx[i] = int'(body_x[i*COORD_W +: COORD_W]);
          m_sy[i] = int'(body_y[i*COORD_W +: COORD_W]);
        end
        m_len = (int'(body_len) > MAX_SEG) ? MAX_SEG : int'(body_len);
        m_ovf = 0; m_busy_left = 0; m_list.delete();
        m_pending = line_start;
        m_pend_y  = int'(next_y);
      end else if (line_start) begin
        m_start(int'(next_y));
      end else if (m_pending) begin
        m_start(m_pend_y);
      end else if (m_busy_left > 0) begin
        m_busy_left--;
        if (m_busy_left == 0) begin
          m_list = m_new;
          if (m_new_ovf) m_ovf = 1;
        end
      end
    end
    #1;
    check("cyc_pixel_on", pixel_on, m_pix_on);
    check("cyc_head_on", head_on, m_head_on);
    check("cyc_busy", busy, m_busy_left > 0);
    if (m_busy_left == 0 && !m_pending) check("cyc_overflow", overflow, m_ovf);
  end

  task automatic set_seg(input int i, input int x, input int y);
    body_x[i*COORD_W +: COORD_W] = COORD_W'(x);
    body_y[i*COORD_W +: COORD_W] = COORD_W'(y);
  endtask

  task automatic frame();
    frame_start = 1'b1; @(negedge clk); frame_start = 1'b0;
  endtask

  task automatic line(input int y);
    next_y = COORD_W'(y); line_start = 1'b1; @(negedge clk); line_start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 100) begin @(negedge clk); n++; end
    check("scan_timeout", busy, 0);
  endtask

  task automatic probe(input string nm, input int x, input bit e_on, input bit e_hd);
    pix_valid = 1'b1; pix_x = COORD_W'(x);
    @(posedge clk); #2;
    check({nm, "_on"}, pixel_on, e_on);
    check({nm, "_head"}, head_on, e_hd);
    check({nm, "_model"}, m_pix_on, e_on);
    @(negedge clk); pix_valid = 1'b0;
  endtask

  initial begin
    int cnt;
    repeat (2) @(negedge clk);
    check("rst_pixel_on", pixel_on, 0);
    check("rst_busy", busy, 0);
    check("rst_overflow", overflow, 0);
    rst = 1'b0;
    @(negedge clk);

    // 1: single head segment
    set_seg(0, 300, 300); body_len = 1;
    frame(); line(302); wait_idle();
    probe("t1_304", 304, 1, 1);
    probe("t1_305", 305, 0, 0);
    probe("t1_300", 300, 1, 1);
    line(305); wait_idle();
    probe("t1_offline", 302, 0, 0);

    // 2: three segments in a row, busy duration
    set_seg(1, 295, 300); set_seg(2, 290, 300); body_len = 3;
    frame(); line(300);
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      if (busy) cnt++;
      @(negedge clk);
    end
    check("t2_busy_cycles", cnt, 3);
    for (int x = 288; x <= 306; x++)
      probe("t2_sweep", x, (x >= 290 && x <= 304), (x >= 300 && x <= 304));

    // 3: snapshot isolation
    body_len = 1; set_seg(0, 300, 300);
    frame(); set_seg(0, 400, 300);
    line(300); wait_idle();
    probe("t3_old", 302, 1, 1);
    probe("t3_new_hidden", 402, 0, 0);
    frame(); line(300); wait_idle();
    probe("t3_new", 402, 1, 1);
    probe("t3_old_gone", 302, 0, 0);

    // clamp: body_len above MAX_SEG
    for (int i = 0; i < MAX_SEG; i++) set_seg(i, 0, 900);
    set_seg(MAX_SEG - 1, 500, 500); body_len = 40;
    frame(); line(502); wait_idle();
    probe("clamp_last", 502, 1, 0);

    // 4: overflow on 10 stacked segments
    for (int i = 0; i < 10; i++) set_seg(i, 100 + 20 * i, 200);
    body_len = 10;
    frame(); line(200); wait_idle();
    check("t4_overflow", overflow, 1);
    probe("t4_seg0", 100, 1, 1);
    probe("t4_seg7", 240, 1, 0);
    probe("t4_seg8_dropped", 260, 0, 0);
    frame();
    check("t4_overflow_clr", overflow, 0);

    // 5: empty snapshot, then frame+line together
    body_len = 0;
    frame(); line(62); wait_idle();
    probe("t5_empty", 52, 0, 0);
    set_seg(0, 50, 60); set_seg(1, 70, 60); body_len = 2;
    next_y = 10'd62; frame_start = 1'b1; line_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0; line_start = 1'b0; next_y = 10'd0;
    wait_idle();
    probe("t5_head", 52, 1, 1);
    probe("t5_body", 72, 1, 0);
    probe("t5_gap", 75, 0, 0);
    line(62);
    check("t5_busy_mid", busy, 1);
    rst = 1'b1; #1;
    check("t5_rst_busy", busy, 0);
    check("t5_rst_pix", pixel_on, 0);
    @(negedge clk); rst = 1'b0; @(negedge clk);

    // 6: right edge, no wrap
    set_seg(0, 1022, 100); body_len = 1;
    frame(); line(101); wait_idle();
    probe("t6_1023", 1023, 1, 1);
    probe("t6_0", 0, 0, 0);
    probe("t6_1022", 1022, 1, 1);
    probe("t6_1021", 1021, 0, 0);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
